// File: rtl/id_ex_stage_pkg.sv
// Shared pipeline definitions: control field widths, control bit positions and
// the ID/EX hazard state encoding.
package id_ex_stage_pkg;

    localparam int WB_W = 2;
    localparam int M_W  = 2;
    localparam int EX_W = 4;

    localparam int REG_WRITE  = 1;
    localparam int MEM_TO_REG = 0;
    localparam int MEM_READ   = 1;
    localparam int MEM_WRITE  = 0;
    localparam int REG_DST    = 3;
    localparam int ALU_SRC    = 2;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_BUBBLE = 1'b1
    } ie_state_e;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detect: a load in EX whose destination is read
// by the instruction in ID. A load targeting r0 never creates a hazard.
module load_use_detect (
    input  logic       id_valid,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rt,
    input  logic       ex_valid,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rt,
    output logic       hz
);

    logic rs_match;
    logic rt_match;

    assign rs_match = (ex_rt == id_rs);
    assign rt_match = id_uses_rt & (ex_rt == id_rt);
    assign hz = id_valid & ex_valid & ex_mem_read & (ex_rt != 5'd0) & (rs_match | rt_match);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with single-bubble load-use stall insertion,
// branch flush and a saturating count of inserted bubbles.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              id_valid,
    input  logic [DATA_W-1:0] id_pc_plus4,
    input  logic [DATA_W-1:0] id_read_data_1,
    input  logic [DATA_W-1:0] id_read_data_2,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic [4:0]        id_rd,
    input  logic              id_uses_rt,
    input  logic [WB_W-1:0]   id_wb,
    input  logic [M_W-1:0]    id_m,
    input  logic [EX_W-1:0]   id_ex,
    input  logic              flush,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_pc_plus4,
    output logic [DATA_W-1:0] ex_read_data_1,
    output logic [DATA_W-1:0] ex_read_data_2,
    output logic [DATA_W-1:0] ex_imm,
    output logic [4:0]        ex_rs,
    output logic [4:0]        ex_rt,
    output logic [4:0]        ex_rd,
    output logic [WB_W-1:0]   ex_wb,
    output logic [M_W-1:0]    ex_m,
    output logic [EX_W-1:0]   ex_ex,
    output logic              stall,
    output logic [CNT_W-1:0]  stall_count
);

    ie_state_e         state_q, state_d;
    logic              hz;
    logic              ex_valid_q, ex_valid_d;
    logic [DATA_W-1:0] ex_pc_plus4_q, ex_pc_plus4_d;
    logic [DATA_W-1:0] ex_read_data_1_q, ex_read_data_1_d;
    logic [DATA_W-1:0] ex_read_data_2_q, ex_read_data_2_d;
    logic [DATA_W-1:0] ex_imm_q, ex_imm_d;
    logic [4:0]        ex_rs_q, ex_rs_d;
    logic [4:0]        ex_rt_q, ex_rt_d;
    logic [4:0]        ex_rd_q, ex_rd_d;
    logic [WB_W-1:0]   ex_wb_q, ex_wb_d;
    logic [M_W-1:0]    ex_m_q, ex_m_d;
    logic [EX_W-1:0]   ex_ex_q, ex_ex_d;
    logic [CNT_W-1:0]  stall_count_q, stall_count_d;

    load_use_detect u_load_use_detect (
        .id_valid    (id_valid),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_uses_rt  (id_uses_rt),
        .ex_valid    (ex_valid_q),
        .ex_mem_read (ex_m_q[MEM_READ]),
        .ex_rt       (ex_rt_q),
        .hz          (hz)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= ST_RUN;
            ex_valid_q       <= 1'b0;
            ex_pc_plus4_q    <= '0;
            ex_read_data_1_q <= '0;
            ex_read_data_2_q <= '0;
            ex_imm_q         <= '0;
            ex_rs_q          <= '0;
            ex_rt_q          <= '0;
            ex_rd_q          <= '0;
            ex_wb_q          <= '0;
            ex_m_q           <= '0;
            ex_ex_q          <= '0;
            stall_count_q    <= '0;
        end else begin
            state_q          <= state_d;
            ex_valid_q       <= ex_valid_d;
            ex_pc_plus4_q    <= ex_pc_plus4_d;
            ex_read_data_1_q <= ex_read_data_1_d;
            ex_read_data_2_q <= ex_read_data_2_d;
            ex_imm_q         <= ex_imm_d;
            ex_rs_q          <= ex_rs_d;
            ex_rt_q          <= ex_rt_d;
            ex_rd_q          <= ex_rd_d;
            ex_wb_q          <= ex_wb_d;
            ex_m_q           <= ex_m_d;
            ex_ex_q          <= ex_ex_d;
            stall_count_q    <= stall_count_d;
        end
    end

    // BUBBLE lasts exactly one cycle; flush already forces stall low.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:    if (stall) state_d = ST_BUBBLE;
            ST_BUBBLE: state_d = ST_RUN;
            default:   state_d = ST_RUN;
        endcase
    end

    always_comb begin
        stall = hz & ~flush & (state_q == ST_RUN);
    end

    // Datapath fields always track ID; only valid and control bits are squashed.
    always_comb begin
        ex_pc_plus4_d    = id_pc_plus4;
        ex_read_data_1_d = id_read_data_1;
        ex_read_data_2_d = id_read_data_2;
        ex_imm_d         = id_imm;
        ex_rs_d          = id_rs;
        ex_rt_d          = id_rt;
        ex_rd_d          = id_rd;
        ex_valid_d       = id_valid;
        ex_wb_d          = id_valid ? id_wb : '0;
        ex_m_d           = id_valid ? id_m  : '0;
        ex_ex_d          = id_valid ? id_ex : '0;
        if (flush || stall) begin
            ex_valid_d = 1'b0;
            ex_wb_d    = '0;
            ex_m_d     = '0;
            ex_ex_d    = '0;
        end
        stall_count_d = stall_count_q;
        if (stall && !(&stall_count_q)) stall_count_d = stall_count_q + CNT_W'(1);
    end

    assign ex_valid       = ex_valid_q;
    assign ex_pc_plus4    = ex_pc_plus4_q;
    assign ex_read_data_1 = ex_read_data_1_q;
    assign ex_read_data_2 = ex_read_data_2_q;
    assign ex_imm         = ex_imm_q;
    assign ex_rs          = ex_rs_q;
    assign ex_rt          = ex_rt_q;
    assign ex_rd          = ex_rd_q;
    assign ex_wb          = ex_wb_q;
    assign ex_m           = ex_m_q;
    assign ex_ex          = ex_ex_q;
    assign stall_count    = stall_count_q;

endmodule
